// File: rtl/tlc_monitor.sv
// ============================================================================
// tlc_monitor : traffic-light safety monitor (decode, order, duration checks)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tlc_monitor #(
  parameter int GREEN_CYC  = 31,
  parameter int YELLOW_CYC = 6,
  parameter int LEFT_CYC   = 11,
  parameter int TOL        = 1,
  parameter int DARK_MAX   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_green,
  input  logic       h_yellow,
  input  logic       h_left,
  input  logic       h_red,
  input  logic       v_green,
  input  logic       v_yellow,
  input  logic       v_left,
  input  logic       v_red,
  input  logic       fault_clr,
  output logic [2:0] phase,
  output logic [7:0] phase_len,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] c_ph_dark = 3'd0;
  localparam logic [2:0] c_ph_hg   = 3'd1;
  localparam logic [2:0] c_ph_hy   = 3'd2;
  localparam logic [2:0] c_ph_hl   = 3'd3;
  localparam logic [2:0] c_ph_vg   = 3'd4;
  localparam logic [2:0] c_ph_vy   = 3'd5;
  localparam logic [2:0] c_ph_vl   = 3'd6;
  localparam logic [2:0] c_ph_ill  = 3'd7;

  localparam logic [2:0] c_code_none     = 3'd0;
  localparam logic [2:0] c_code_conflict = 3'd1;
  localparam logic [2:0] c_code_seq      = 3'd2;
  localparam logic [2:0] c_code_dark     = 3'd3;
  localparam logic [2:0] c_code_over     = 3'd4;
  localparam logic [2:0] c_code_under    = 3'd5;
  localparam logic [2:0] c_code_timeout  = 3'd6;

  // Duration bounds: min is the shortest acceptable completed phase,
  // max is the first phase_len value that counts as an overrun.
  localparam logic [8:0] c_g_min = 9'(GREEN_CYC - TOL);
  localparam logic [8:0] c_g_max = 9'(GREEN_CYC + TOL + 1);
  localparam logic [8:0] c_y_min = 9'(YELLOW_CYC - TOL);
  localparam logic [8:0] c_y_max = 9'(YELLOW_CYC + TOL + 1);
  localparam logic [8:0] c_l_min = 9'(LEFT_CYC - TOL);
  localparam logic [8:0] c_l_max = 9'(LEFT_CYC + TOL + 1);
  localparam logic [7:0] c_dark_lim = 8'(DARK_MAX + 1);

  function automatic logic [2:0] f_succ(input logic [2:0] p);
    logic [2:0] s;
    case (p)
      c_ph_hg: s = c_ph_hy;
      c_ph_hy: s = c_ph_hl;
      c_ph_hl: s = c_ph_vg;
      c_ph_vg: s = c_ph_vy;
      c_ph_vy: s = c_ph_vl;
      c_ph_vl: s = c_ph_hg;
      default: s = c_ph_ill;
    endcase
    return s;
  endfunction

  function automatic logic [8:0] f_min(input logic [2:0] p);
    logic [8:0] m;
    case (p)
      c_ph_hg, c_ph_vg: m = c_g_min;
      c_ph_hy, c_ph_vy: m = c_y_min;
      c_ph_hl, c_ph_vl: m = c_l_min;
      default:          m = 9'd0;
    endcase
    return m;
  endfunction

  function automatic logic [8:0] f_max(input logic [2:0] p);
    logic [8:0] m;
    case (p)
      c_ph_hg, c_ph_vg: m = c_g_max;
      c_ph_hy, c_ph_vy: m = c_y_max;
      c_ph_hl, c_ph_vl: m = c_l_max;
      default:          m = 9'h1ff;
    endcase
    return m;
  endfunction

  state_t     r_state;
  logic [7:0] r_dark_cnt;
  logic       r_first_hg;

  logic [7:0] w_lamps;
  logic [2:0] w_sample;
  logic       w_lit;
  logic       w_changed;
  logic [7:0] w_len_next;
  logic [8:0] w_len_ext;
  logic       w_clr_now;
  state_t     w_eff_state;
  logic [7:0] w_eff_dark;
  logic [7:0] w_dark_inc;
  logic       w_v_conf, w_v_seq, w_v_dark, w_v_under, w_v_over, w_v_tmo;
  logic       w_viol;
  logic [2:0] w_code;

  assign w_lamps = {h_green, h_yellow, h_left, h_red, v_green, v_yellow, v_left, v_red};

  always_comb begin
    w_sample = c_ph_ill;
    case (w_lamps)
      8'b0000_0000: w_sample = c_ph_dark;
      8'b1000_0001: w_sample = c_ph_hg;
      8'b0100_0001: w_sample = c_ph_hy;
      8'b0010_0001: w_sample = c_ph_hl;
      8'b0001_1000: w_sample = c_ph_vg;
      8'b0001_0100: w_sample = c_ph_vy;
      8'b0001_0010: w_sample = c_ph_vl;
      default:      w_sample = c_ph_ill;
    endcase
  end

  assign w_lit      = (w_sample != c_ph_dark) && (w_sample != c_ph_ill);
  assign w_changed  = (w_sample != phase);
  assign w_len_ext  = {1'b0, phase_len} + 9'd1;
  assign w_len_next = w_changed ? 8'd1 : ((phase_len == 8'hff) ? 8'hff : w_len_ext[7:0]);

  // A clear is processed as a fresh START, so the sample on the clear edge
  // is itself checked and a violation on that edge re-latches the fault.
  assign w_clr_now   = (r_state == ST_FAULT) && fault_clr;
  assign w_eff_state = w_clr_now ? ST_START : r_state;
  assign w_eff_dark  = w_clr_now ? 8'd0 : r_dark_cnt;
  assign w_dark_inc  = w_eff_dark + 8'd1;

  always_comb begin
    w_v_conf  = 1'b0;
    w_v_seq   = 1'b0;
    w_v_dark  = 1'b0;
    w_v_under = 1'b0;
    w_v_over  = 1'b0;
    w_v_tmo   = 1'b0;
    if (w_eff_state != ST_FAULT) begin
      w_v_conf = (w_sample == c_ph_ill);
      if (w_eff_state == ST_START) begin
        w_v_seq = w_lit && (w_sample != c_ph_hg);
        w_v_tmo = (w_sample == c_ph_dark) && (w_dark_inc == c_dark_lim);
      end else begin
        w_v_dark  = w_changed && (w_sample == c_ph_dark);
        w_v_seq   = w_changed && w_lit && (w_sample != f_succ(phase));
        w_v_under = w_changed && !((phase == c_ph_hg) && r_first_hg) &&
                    ({1'b0, phase_len} < f_min(phase));
        w_v_over  = !w_changed && (w_len_ext == f_max(phase));
      end
    end
  end

  always_comb begin
    w_code = c_code_none;
    if      (w_v_conf)  w_code = c_code_conflict;
    else if (w_v_seq)   w_code = c_code_seq;
    else if (w_v_dark)  w_code = c_code_dark;
    else if (w_v_under) w_code = c_code_under;
    else if (w_v_over)  w_code = c_code_over;
    else if (w_v_tmo)   w_code = c_code_timeout;
  end

  assign w_viol = w_v_conf | w_v_seq | w_v_dark | w_v_under | w_v_over | w_v_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_START;
      r_dark_cnt <= 8'd0;
      r_first_hg <= 1'b0;
      phase      <= c_ph_dark;
      phase_len  <= 8'd0;
      fault      <= 1'b0;
      fault_code <= c_code_none;
    end else begin
      phase     <= w_sample;
      phase_len <= w_len_next;
      if (w_viol) begin
        r_state    <= ST_FAULT;
        fault      <= 1'b1;
        fault_code <= w_code;
      end else begin
        case (w_eff_state)
          ST_START: begin
            fault      <= 1'b0;
            fault_code <= c_code_none;
            if (w_sample == c_ph_dark) begin
              r_state    <= ST_START;
              r_dark_cnt <= w_dark_inc;
            end else begin
              r_state    <= ST_RUN;
              r_dark_cnt <= 8'd0;
              r_first_hg <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_changed) r_first_hg <= 1'b0;
          end
          default: begin
            r_state <= ST_FAULT;
          end
        endcase
      end
    end
  end

  assign flash_en = fault;

endmodule

`default_nettype wire

// File: tb/tb_tlc_monitor.sv
// ============================================================================
// tb_tlc_monitor : scoreboard bench for tlc_monitor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tlc_monitor;

  localparam logic [7:0] P_DARK = 8'b0000_0000;
  localparam logic [7:0] P_HG   = 8'b1000_0001;
  localparam logic [7:0] P_HY   = 8'b0100_0001;
  localparam logic [7:0] P_HL   = 8'b0010_0001;
  localparam logic [7:0] P_VG   = 8'b0001_1000;
  localparam logic [7:0] P_VY   = 8'b0001_0100;
  localparam logic [7:0] P_VL   = 8'b0001_0010;
  localparam logic [7:0] P_CONF = 8'b1000_1000;

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] len;
    logic       f;
    logic [2:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lamps = P_DARK;
  logic       fault_clr = 1'b0;
  logic [2:0] phase;
  logic [7:0] phase_len;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_en;

  exp_t       sb[$];
  exp_t       r_e;
  logic [2:0] m_phase;
  logic [7:0] m_len;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  tlc_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .h_green    (lamps[7]),
    .h_yellow   (lamps[6]),
    .h_left     (lamps[5]),
    .h_red      (lamps[4]),
    .v_green    (lamps[3]),
    .v_yellow   (lamps[2]),
    .v_left     (lamps[1]),
    .v_red      (lamps[0]),
    .fault_clr  (fault_clr),
    .phase      (phase),
    .phase_len  (phase_len),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_en   (flash_en)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [2:0] f_dec(input logic [7:0] p);
    case (p)
      P_DARK:  return 3'd0;
      P_HG:    return 3'd1;
      P_HY:    return 3'd2;
      P_HL:    return 3'd3;
      P_VG:    return 3'd4;
      P_VY:    return 3'd5;
      P_VL:    return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Called at a negedge: apply one cycle of stimulus, queue its expectation.
  task automatic step(input logic [7:0] p, input logic clr, input logic ef, input logic [2:0] ec);
    exp_t e;
    logic [2:0] ph;
    lamps     = p;
    fault_clr = clr;
    ph = f_dec(p);
    if (ph != m_phase) m_len = 8'd1;
    else if (m_len != 8'hff) m_len = m_len + 8'd1;
    m_phase = ph;
    e.ph = m_phase; e.len = m_len; e.f = ef; e.code = ec;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] p, input int n, input logic ef, input logic [2:0] ec);
    for (int i = 0; i < n; i++) step(p, 1'b0, ef, ec);
  endtask

  // Asynchronous reset in the middle of the low clock phase.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_len"},   32'(phase_len), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_code"},  32'(fault_code), 32'd0);
    chk({tag, "_flash"}, 32'(flash_en), 32'd0);
    lamps     = P_DARK;
    fault_clr = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    m_phase = 3'd0;
    m_len   = 8'd0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      r_e = sb.pop_front();
      chk("phase",      32'(phase),      32'(r_e.ph));
      chk("phase_len",  32'(phase_len),  32'(r_e.len));
      chk("fault",      32'(fault),      32'(r_e.f));
      chk("fault_code", 32'(fault_code), 32'(r_e.code));
      chk("flash_en",   32'(flash_en),   32'(r_e.f));
    end
  end

  initial begin
    m_phase = 3'd0;
    m_len   = 8'd0;
    @(negedge clk);
    @(negedge clk);
    do_reset("rst");

    // Legal loops with boundary lengths (N-TOL and N+TOL) mixed in.
    step(P_DARK, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      hold(P_HG, (k == 0) ? 30 : 31, 1'b0, 3'd0);
      hold(P_HY, (k == 1) ? 5 : ((k == 2) ? 7 : 6), 1'b0, 3'd0);
      hold(P_HL, (k == 1) ? 10 : 11, 1'b0, 3'd0);
      hold(P_VG, (k == 2) ? 32 : 31, 1'b0, 3'd0);
      hold(P_VY, 6, 1'b0, 3'd0);
      hold(P_VL, (k == 2) ? 12 : 11, 1'b0, 3'd0);
    end

    // Conflict during HG, fault persists and later violations are ignored.
    hold(P_HG, 5, 1'b0, 3'd0);
    step(P_CONF, 1'b0, 1'b1, 3'd1);
    hold(P_HG, 3, 1'b1, 3'd1);
    hold(P_HY, 10, 1'b1, 3'd1);

    // Clear, then short first HG is exempt from underrun; HG->HL is sequence.
    step(P_DARK, 1'b1, 1'b0, 3'd0);
    hold(P_DARK, 2, 1'b0, 3'd0);
    hold(P_HG, 3, 1'b0, 3'd0);
    step(P_HL, 1'b0, 1'b1, 3'd2);

    // Unexpected dark in RUN.
    step(P_DARK, 1'b1, 1'b0, 3'd0);
    hold(P_HG, 31, 1'b0, 3'd0);
    step(P_DARK, 1'b0, 1'b1, 3'd3);

    // Overrun on the 8th HY sample.
    step(P_DARK, 1'b1, 1'b0, 3'd0);
    hold(P_HG, 31, 1'b0, 3'd0);
    hold(P_HY, 7, 1'b0, 3'd0);
    step(P_HY, 1'b0, 1'b1, 3'd4);
    hold(P_HY, 2, 1'b1, 3'd4);

    // Clear, clean run, then underrun HY=4.
    step(P_DARK, 1'b1, 1'b0, 3'd0);
    step(P_DARK, 1'b0, 1'b0, 3'd0);
    hold(P_HG, 31, 1'b0, 3'd0);
    hold(P_HY, 6, 1'b0, 3'd0);
    hold(P_HL, 11, 1'b0, 3'd0);
    hold(P_VG, 31, 1'b0, 3'd0);
    hold(P_VY, 6, 1'b0, 3'd0);
    hold(P_VL, 11, 1'b0, 3'd0);
    hold(P_HG, 31, 1'b0, 3'd0);
    hold(P_HY, 4, 1'b0, 3'd0);
    step(P_HL, 1'b0, 1'b1, 3'd5);

    // Reset while in FAULT; dark timeout on the 5th dark sample.
    do_reset("rst_fault");
    hold(P_DARK, 4, 1'b0, 3'd0);
    step(P_DARK, 1'b0, 1'b1, 3'd6);
    step(P_DARK, 1'b0, 1'b1, 3'd6);

    // Start with VG is a sequence fault.
    do_reset("rst_fault2");
    step(P_VG, 1'b0, 1'b1, 3'd2);

    // Conflict on the same edge as the clear wins.
    step(P_CONF, 1'b1, 1'b1, 3'd1);
    step(P_DARK, 1'b0, 1'b1, 3'd1);
    step(P_DARK, 1'b1, 1'b0, 3'd0);
    hold(P_HG, 10, 1'b0, 3'd0);

    // Reset mid-phase.
    do_reset("rst_mid");
    step(P_DARK, 1'b0, 1'b0, 3'd0);

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
